// File: rtl/display_alphahex_scroll_if.sv
// display_alphahex_scroll_if: message/mode inputs and segment/strobe outputs of the scrolling display driver.
interface display_alphahex_scroll_if #(
    parameter int NUM_DIGITS = 8,
    parameter int MSG_LEN    = 16,
    parameter int CHAR_W     = 6
);
    logic [MSG_LEN*CHAR_W-1:0] msg_in;
    logic                      load_in;
    logic [1:0]                mode_in;
    logic [NUM_DIGITS-1:0]     dp_in;
    logic [6:0]                seg_out;
    logic                      dp_out;
    logic [NUM_DIGITS-1:0]     strobe_out;
    logic                      wrap_out;

    modport master (output msg_in, load_in, mode_in, dp_in, input seg_out, dp_out, strobe_out, wrap_out);
    modport slave  (input msg_in, load_in, mode_in, dp_in, output seg_out, dp_out, strobe_out, wrap_out);
endinterface

// File: rtl/display_alphahex_scroll.sv
// display_alphahex_scroll: multiplexed 7-segment driver with timed scrolling, blinking and per-digit decimal points.
module display_alphahex_scroll #(
    parameter int NUM_DIGITS    = 8,
    parameter int MSG_LEN       = 16,
    parameter int CHAR_W        = 6,
    parameter int DWELL_CYCLES  = 8192,
    parameter int SCROLL_CYCLES = 19_500_000,
    parameter int BLINK_CYCLES  = 32_500_000
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    display_alphahex_scroll_if.slave   bus
);
    localparam int DIG_W = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam int OFF_W = MSG_LEN > 1 ? $clog2(MSG_LEN) : 1;
    localparam int DWL_W = $clog2(DWELL_CYCLES + 1);
    localparam int SCR_W = $clog2(SCROLL_CYCLES + 1);
    localparam int BLK_W = $clog2(BLINK_CYCLES + 1);

    if (MSG_LEN < NUM_DIGITS) begin : g_len_check
        $error("MSG_LEN must be >= NUM_DIGITS");
    end

    logic [CHAR_W-1:0]     r_buf [MSG_LEN];
    logic [OFF_W-1:0]      r_off;
    logic [DIG_W-1:0]      r_dig;
    logic [DWL_W-1:0]      r_dwell;
    logic [SCR_W-1:0]      r_scroll;
    logic [BLK_W-1:0]      r_blink;
    logic                  r_phase;
    logic [6:0]            r_seg;
    logic                  r_dp;
    logic [NUM_DIGITS-1:0] r_strobe;
    logic                  r_wrap;

    logic                  w_dwell_tc;
    logic                  w_scroll_tc;
    logic                  w_blink_tc;
    logic [OFF_W-1:0]      w_idx;
    logic [CHAR_W-1:0]     w_char;

    function automatic logic [6:0] glyph(input logic [CHAR_W-1:0] c);
        case (int'(c))
            3:       return 7'b100_0110;
            5:       return 7'b000_0110;
            10:      return 7'b110_0001;
            12:      return 7'b100_0111;
            15:      return 7'b100_0000;
            18:      return 7'b100_1110;
            19:      return 7'b001_0010;
            21:      return 7'b100_0001;
            24:      return 7'b000_1001;
            default: return 7'b111_1111;
        endcase
    endfunction

    // Digit d sits p = NUM_DIGITS-1-d places from the left of the scrolling window.
    always_comb begin
        w_dwell_tc  = r_dwell == DWL_W'(DWELL_CYCLES - 1);
        w_scroll_tc = r_scroll == SCR_W'(SCROLL_CYCLES - 1);
        w_blink_tc  = r_blink == BLK_W'(BLINK_CYCLES - 1);
        w_idx       = OFF_W'((int'(r_off) + NUM_DIGITS - 1 - int'(r_dig)) % MSG_LEN);
        w_char      = r_buf[w_idx];
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            for (int k = 0; k < MSG_LEN; k++) r_buf[k] <= '0;
            r_off    <= '0;
            r_dig    <= DIG_W'(NUM_DIGITS - 1);
            r_dwell  <= '0;
            r_scroll <= '0;
            r_blink  <= '0;
            r_phase  <= 1'b1;
            r_seg    <= 7'h7F;
            r_dp     <= 1'b1;
            r_strobe <= '1;
            r_wrap   <= 1'b0;
        end else begin
            r_dwell <= w_dwell_tc ? '0 : r_dwell + 1'b1;
            if (w_dwell_tc) r_dig <= r_dig == '0 ? DIG_W'(NUM_DIGITS - 1) : r_dig - 1'b1;
            if (bus.load_in)
                for (int k = 0; k < MSG_LEN; k++) r_buf[k] <= bus.msg_in[k*CHAR_W +: CHAR_W];
            // A load restarts the scroll and beats a coincident terminal count, so it never wraps.
            if (bus.load_in || !bus.mode_in[0]) begin
                r_scroll <= '0;
                r_off    <= '0;
            end else if (w_scroll_tc) begin
                r_scroll <= '0;
                r_off    <= r_off == OFF_W'(MSG_LEN - 1) ? '0 : r_off + 1'b1;
            end else begin
                r_scroll <= r_scroll + 1'b1;
            end
            r_wrap <= !bus.load_in && bus.mode_in[0] && w_scroll_tc && r_off == OFF_W'(MSG_LEN - 1);
            if (bus.load_in || !bus.mode_in[1]) begin
                r_blink <= '0;
                r_phase <= 1'b1;
            end else begin
                r_blink <= w_blink_tc ? '0 : r_blink + 1'b1;
                if (w_blink_tc) r_phase <= ~r_phase;
            end
            r_strobe <= r_phase ? ~(NUM_DIGITS'(1) << r_dig) : '1;
            r_seg    <= r_phase ? glyph(w_char) : 7'h7F;
            r_dp     <= r_phase ? ~bus.dp_in[r_dig] : 1'b1;
        end
    end

    assign bus.seg_out    = r_seg;
    assign bus.dp_out     = r_dp;
    assign bus.strobe_out = r_strobe;
    assign bus.wrap_out   = r_wrap;
endmodule

// File: tb/tb_display_alphahex_scroll.sv
// tb_display_alphahex_scroll: directed vectors plus randomized run against an event-count reference model.
module tb_display_alphahex_scroll;
    localparam int N = 4, ML = 6, CW = 6, DW = 4, SC = 40, BC = 100;
    localparam logic [6:0] G_J = 7'b110_0001, G_O = 7'b100_0000, G_E = 7'b000_0110, G_R = 7'b100_1110;
    localparam logic [6:0] G_S = 7'b001_0010, G_U = 7'b100_0001, G_C = 7'b100_0110, BL = 7'h7F;

    logic clk_in = 1'b0;
    logic rst_in = 1'b0;

    display_alphahex_scroll_if #(.NUM_DIGITS(N), .MSG_LEN(ML), .CHAR_W(CW)) bus ();

    display_alphahex_scroll #(
        .NUM_DIGITS(N), .MSG_LEN(ML), .CHAR_W(CW),
        .DWELL_CYCLES(DW), .SCROLL_CYCLES(SC), .BLINK_CYCLES(BC)
    ) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .bus(bus.slave)
    );

    always #5 clk_in = ~clk_in;

    int  n_vec = 0;
    int  n_err = 0;
    int  j = 0;
    bit  chk_en = 1'b0;

    function automatic logic [6:0] glyph(input int c);
        case (c)
            3:       return G_C;
            5:       return G_E;
            10:      return G_J;
            12:      return 7'b100_0111;
            15:      return G_O;
            18:      return G_R;
            19:      return G_S;
            21:      return G_U;
            24:      return 7'b000_1001;
            default: return BL;
        endcase
    endfunction

    function automatic logic [ML*CW-1:0] pack6(input int a, b, c, d, e, f);
        return {CW'(f), CW'(e), CW'(d), CW'(c), CW'(b), CW'(a)};
    endfunction

    // Model state: edges since reset, since the scroll run began, since the blink run began.
    int m_n, m_s, m_b;
    logic [CW-1:0] m_buf [ML];
    logic [6:0]    e_seg;
    logic          e_dp, e_wrap;
    logic [N-1:0]  e_strobe;

    function automatic int mdig(input int n); return N - 1 - (n / DW) % N; endfunction
    function automatic int moff(input int s); return (s / SC) % ML; endfunction
    function automatic bit mph(input int b); return ((b / BC) % 2) == 0; endfunction

    always @(posedge clk_in) begin
        if (!rst_in) begin
            m_n <= 0;
            m_s <= 0;
            m_b <= 0;
            for (int k = 0; k < ML; k++) m_buf[k] <= '0;
            e_seg    <= BL;
            e_dp     <= 1'b1;
            e_strobe <= '1;
            e_wrap   <= 1'b0;
        end else begin
            e_strobe <= mph(m_b) ? ~(N'(1) << mdig(m_n)) : '1;
            e_seg    <= mph(m_b) ? glyph(int'(m_buf[(moff(m_s) + N - 1 - mdig(m_n)) % ML])) : BL;
            e_dp     <= mph(m_b) ? ~bus.dp_in[mdig(m_n)] : 1'b1;
            m_n      <= m_n + 1;
            if (bus.load_in) begin
                for (int k = 0; k < ML; k++) m_buf[k] <= bus.msg_in[k*CW +: CW];
                m_s    <= 0;
                m_b    <= 0;
                e_wrap <= 1'b0;
            end else begin
                m_s    <= bus.mode_in[0] ? m_s + 1 : 0;
                m_b    <= bus.mode_in[1] ? m_b + 1 : 0;
                e_wrap <= bus.mode_in[0] && ((m_s + 1) % SC == 0) && (((m_s + 1) / SC) % ML == 0);
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk_in) begin
        if (chk_en) begin
            check("model_seg", 32'(bus.seg_out), 32'(e_seg));
            check("model_dp", 32'(bus.dp_out), 32'(e_dp));
            check("model_strobe", 32'(bus.strobe_out), 32'(e_strobe));
            check("model_wrap", 32'(bus.wrap_out), 32'(e_wrap));
        end
    end

    task automatic adv(input int n);
        repeat (n) @(negedge clk_in);
        j += n;
    endtask

    task automatic find(input logic [N-1:0] s, input logic [6:0] g, input string nm);
        int w = 0;
        while (bus.strobe_out !== s && w < 20) begin
            adv(1);
            w++;
        end
        check({nm, "_strobe"}, 32'(bus.strobe_out), 32'(s));
        check({nm, "_seg"}, 32'(bus.seg_out), 32'(g));
    endtask

    typedef struct {
        int           k;
        logic [N-1:0] strobe;
        logic [6:0]   seg;
    } vec_t;
    vec_t tbl [8];

    initial begin
        int cur;
        int lows;
        int bad;
        tbl[0] = '{1, 4'b0111, G_J};
        tbl[1] = '{3, 4'b0111, G_J};
        tbl[2] = '{4, 4'b1011, G_O};
        tbl[3] = '{8, 4'b1101, G_E};
        tbl[4] = '{12, 4'b1110, BL};
        tbl[5] = '{15, 4'b1110, BL};
        tbl[6] = '{16, 4'b0111, G_J};
        tbl[7] = '{20, 4'b1011, G_O};
        bus.msg_in  = '0;
        bus.load_in = 1'b0;
        bus.mode_in = 2'b00;
        bus.dp_in   = '0;
        repeat (3) @(negedge clk_in);
        chk_en = 1'b1;
        check("rst_strobe", 32'(bus.strobe_out), 32'(4'b1111));
        check("rst_seg", 32'(bus.seg_out), 32'(BL));
        check("rst_dp", 32'(bus.dp_out), 32'(1'b1));
        check("rst_wrap", 32'(bus.wrap_out), 32'(1'b0));
        // Static: load JOE0RO on the first edge after reset release.
        rst_in = 1'b1;
        bus.msg_in  = pack6(10, 15, 5, 0, 18, 15);
        bus.load_in = 1'b1;
        @(negedge clk_in);
        bus.load_in = 1'b0;
        cur = 0;
        foreach (tbl[i]) begin
            repeat (tbl[i].k - cur) @(negedge clk_in);
            cur = tbl[i].k;
            check($sformatf("static_strobe_%0d", tbl[i].k), 32'(bus.strobe_out), 32'(tbl[i].strobe));
            check($sformatf("static_seg_%0d", tbl[i].k), 32'(bus.seg_out), 32'(tbl[i].seg));
        end
        // Scroll: reload in mode 01, then read window 4 and the natural wrap.
        bus.mode_in = 2'b01;
        bus.load_in = 1'b1;
        adv(1);
        bus.load_in = 1'b0;
        j = 0;
        adv(165);
        find(4'b0111, G_R, "win4_d3");
        find(4'b1011, G_O, "win4_d2");
        find(4'b1101, G_J, "win4_d1");
        find(4'b1110, G_O, "win4_d0");
        adv(239 - j);
        check("wrap_before", 32'(bus.wrap_out), 32'(1'b0));
        adv(1);
        check("wrap_pulse", 32'(bus.wrap_out), 32'(1'b1));
        adv(1);
        check("wrap_after", 32'(bus.wrap_out), 32'(1'b0));
        // Load on the terminal count that would otherwise wrap.
        adv(479 - j);
        bus.msg_in  = pack6(19, 21, 3, 3, 5, 19);
        bus.load_in = 1'b1;
        adv(1);
        bus.load_in = 1'b0;
        check("collide_wrap", 32'(bus.wrap_out), 32'(1'b0));
        j = 0;
        adv(2);
        find(4'b0111, G_S, "collide_new");
        // Leave scroll at offset 3.
        adv(140 - j);
        find(4'b1011, G_E, "win3_d2");
        bus.mode_in = 2'b00;
        adv(2);
        find(4'b1011, G_U, "exit_win0_d2");
        // Blink.
        bus.mode_in = 2'b10;
        bus.dp_in   = 4'b1111;
        bus.msg_in  = pack6(10, 15, 5, 0, 18, 15);
        bus.load_in = 1'b1;
        adv(1);
        bus.load_in = 1'b0;
        j = 0;
        adv(100);
        check("blink_on_100", 32'(bus.strobe_out == 4'b1111), 32'(1'b0));
        adv(1);
        check("blink_off_strobe", 32'(bus.strobe_out), 32'(4'b1111));
        check("blink_off_seg", 32'(bus.seg_out), 32'(BL));
        check("blink_off_dp", 32'(bus.dp_out), 32'(1'b1));
        adv(99);
        check("blink_off_200", 32'(bus.strobe_out), 32'(4'b1111));
        adv(1);
        check("blink_resume", 32'(bus.strobe_out == 4'b1111), 32'(1'b0));
        // Decimal point on digit 2 only.
        bus.mode_in = 2'b00;
        bus.dp_in   = 4'b0100;
        adv(2);
        lows = 0;
        bad  = 0;
        for (int c = 0; c < 32; c++) begin
            adv(1);
            if (bus.dp_out === 1'b0) begin
                lows++;
                if (bus.strobe_out !== 4'b1011) bad++;
            end
        end
        check("dp_low_count", 32'(lows), 32'(8));
        check("dp_wrong_digit", 32'(bad), 32'(0));
        // Reset in the middle of a scroll.
        bus.mode_in = 2'b01;
        adv(50);
        rst_in = 1'b0;
        adv(1);
        check("midrst_strobe", 32'(bus.strobe_out), 32'(4'b1111));
        check("midrst_seg", 32'(bus.seg_out), 32'(BL));
        check("midrst_wrap", 32'(bus.wrap_out), 32'(1'b0));
        rst_in = 1'b1;
        adv(20);
        // Randomized traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            rst_in      = ($urandom % 900) != 0;
            bus.load_in = ($urandom % 300) == 0;
            if (bus.load_in)
                for (int k = 0; k < ML; k++) bus.msg_in[k*CW +: CW] = CW'($urandom_range(0, 31));
            if ($urandom % 150 == 0) bus.mode_in = 2'($urandom);
            bus.dp_in = N'($urandom);
            adv(1);
        end
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/display_alphahex_scroll.md
Name: display_alphahex_scroll

Overview:
- Parametrised successor to the fixed 8-digit alphanumeric 7-segment driver.
- Drives NUM_DIGITS multiplexed digits from a latched message buffer of MSG_LEN character codes.
- Adds three behaviours the old driver lacks: timed scrolling, whole-display blinking, and per-digit decimal points.
- Sits in top_level in place of the fixed driver, e.g. to scroll game status or scores on the board's 8-digit display.

Parameters:
- NUM_DIGITS, 8, number of physical digits (>=1).
- MSG_LEN, 16, characters in message buffer (>=NUM_DIGITS; elaboration error otherwise).
- CHAR_W, 6, bits per character code.
- DWELL_CYCLES, 8192, clocks each digit is strobed.
- SCROLL_CYCLES, 19_500_000, clocks per scroll step (0.3 s at 65 MHz).
- BLINK_CYCLES, 32_500_000, clocks per blink half-period.

Ports:
- clk_in  input  1  system clock (65 MHz).
- rst_in  input  1  reset.
- msg_in  input  MSG_LEN*CHAR_W  message; char k = msg_in[k*CHAR_W +: CHAR_W].
- load_in  input  1  single-cycle pulse: latch msg_in.
- mode_in  input  2  00 static, 01 scroll, 10 blink, 11 scroll+blink.
- dp_in  input  NUM_DIGITS  decimal-point enables, active-high; bit d = digit d.
- seg_out  output  7  segments {g,f,e,d,c,b,a}, active-low.
- dp_out  output  1  decimal point, active-low.
- strobe_out  output  NUM_DIGITS  digit enables, active-low one-hot; bit NUM_DIGITS-1 = leftmost digit.
- wrap_out  output  1  one-cycle pulse when scroll offset wraps to 0.

Behaviour:
- Interface: one clock; reset is synchronous and active-low. Ports are clk_in and rst_in.
- Reset (rst_in=0 at posedge):
  - buffer all 0 (blank); offset 0; all timers 0; blink phase ON; scan digit = NUM_DIGITS-1.
  - seg_out=7'h7F; dp_out=1; strobe_out all 1s; wrap_out=0.
- Glyph ROM, other codes blank (7'b111_1111):
  - 0 blank; 3 C 100_0110; 5 E 000_0110; 10 J 110_0001; 12 L 100_0111;
  - 15 O 100_0000; 18 R 100_1110; 19 S 001_0010; 21 U 100_0001; 24 X 000_1001.
  - Codes >=27 render blank.
- Scan:
  - Dwell counter 0..DWELL_CYCLES-1.
  - At terminal count the scan digit decrements, NUM_DIGITS-1 down to 0, then back to NUM_DIGITS-1.
  - Scan is not disturbed by load_in or mode changes.
- Character mapping: physical digit d (p = NUM_DIGITS-1-d, position from left) shows buffer[(offset+p) mod MSG_LEN].
- Outputs are registered:
  - seg_out, dp_out and strobe_out reflect the current scan digit one cycle after the scan index updates.
  - All three change in the same cycle.
  - First strobe after reset appears on the 2nd cycle after reset release.
- Scroll (mode_in[0]=1):
  - Scroll timer counts 0..SCROLL_CYCLES-1; on terminal count offset increments mod MSG_LEN.
  - On the increment from MSG_LEN-1 to 0, wrap_out=1 for exactly that cycle.
- Static (mode_in[0]=0): offset held at 0 and scroll timer held at 0. Leaving scroll mode forces offset to 0 on the next cycle.
- Blink (mode_in[1]=1):
  - Blink timer toggles phase every BLINK_CYCLES.
  - Phase OFF forces strobe_out all 1s, seg_out 7'h7F and dp_out 1.
  - With mode_in[1]=0, phase is forced ON and the timer is held at 0.
- load_in:
  - buffer<=msg_in; offset<=0; scroll timer<=0; blink timer<=0; phase<=ON.
  - msg_in is ignored when load_in=0.
- Simultaneous load_in and scroll terminal count: load wins, offset=0, no wrap_out.
- Reset mid-scroll or mid-blink: all state returns to reset values in the same cycle.
- dp_out = ~dp_in[d] for the current scan digit d, sampled live rather than latched.

Test Plan:
Bench parameters: NUM_DIGITS=4, MSG_LEN=6, DWELL_CYCLES=4, SCROLL_CYCLES=40, BLINK_CYCLES=100.
1. Reset/static:
   - Stimulus: hold rst_in=0 for 3 cycles, release; then load chars {J,O,E,0,R,O} (k=0..5), mode 00.
   - During reset: strobe_out=4'b1111, seg_out=7'h7F.
   - After load: strobe sequence 0111,1011,1101,1110 every 4 cycles, seg_out J,O,E,blank repeating.
2. Scroll wrap, mode 01:
   - Offset increments every 40 cycles; after step 1 the leftmost digit shows O (110_0001 → 100_0000).
   - After 6 steps (240 cycles) offset=0 and wrap_out pulses high for 1 cycle.
   - At offset 4 the digits read R,O,J,O (window wrap-around).
3. Blink, mode 10: strobe_out=1111 and seg_out=7'h7F for cycles 100–199, normal scan resumes at 200; dp_out stays 1 while OFF.
4. Load collision: assert load_in on the scroll terminal-count cycle → offset=0, wrap_out stays 0, new message shown.
5. Decimal points: dp_in=4'b0100 → dp_out=0 only while strobe_out=1011.
6. Mode exit and mid-run reset:
   - Switch 01→00 at offset 3 → offset 0 next cycle, display back to window 0.
   - rst_in=0 mid-scroll → buffer blank, offset 0, wrap_out 0.
